// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, requester ID width and the
// operand bundle that the arbiter muxes onto the ALU.
package alu_pkg;

    localparam int REQ_ID_W   = 1;
    // Operand width the request bundle is built for; the arbiter's
    // DATA_WIDTH defaults to this value and must stay equal to it.
    localparam int ALU_DATA_W = 4;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        MUL  = 3'b010,
        AND  = 3'b011,
        OR   = 3'b100,
        ADD2 = 3'b101
    } alu_op_e;

    // Raw 3-bit select so that the unused encodings 110/111 can be carried.
    typedef struct packed {
        logic [2:0]                   sel;
        logic signed [ALU_DATA_W-1:0] a;
        logic signed [ALU_DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle of the round-robin ALU arbiter. Signal names carry
// their direction as seen from the arbiter (slave side).
interface alu_rr_arbiter_if #(parameter int DATA_WIDTH = 4);
    import alu_pkg::*;

    logic                          req0_valid_in;
    logic                          req0_ready_out;
    logic [2:0]                    req0_sel_in;
    logic signed [DATA_WIDTH-1:0]  req0_a_in;
    logic signed [DATA_WIDTH-1:0]  req0_b_in;

    logic                          req1_valid_in;
    logic                          req1_ready_out;
    logic [2:0]                    req1_sel_in;
    logic signed [DATA_WIDTH-1:0]  req1_a_in;
    logic signed [DATA_WIDTH-1:0]  req1_b_in;

    logic                          rsp_valid_out;
    logic                          rsp_ready_in;
    logic [REQ_ID_W-1:0]           rsp_id_out;
    logic signed [2*DATA_WIDTH-1:0] rsp_data_out;

    modport slave (
        input  req0_valid_in, req0_sel_in, req0_a_in, req0_b_in,
        input  req1_valid_in, req1_sel_in, req1_a_in, req1_b_in,
        input  rsp_ready_in,
        output req0_ready_out, req1_ready_out,
        output rsp_valid_out, rsp_id_out, rsp_data_out
    );

    modport master (
        output req0_valid_in, req0_sel_in, req0_a_in, req0_b_in,
        output req1_valid_in, req1_sel_in, req1_a_in, req1_b_in,
        output rsp_ready_in,
        input  req0_ready_out, req1_ready_out,
        input  rsp_valid_out, rsp_id_out, rsp_data_out
    );

endinterface

// File: rtl/alu_rr_arbiter_alu.sv
// Shared combinational ALU: signed add/sub/mul and bitwise and/or, all
// sign-extended to a double-width result. Unused opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_W
) (
    input  logic [2:0]                    sel_in,
    input  logic signed [DATA_WIDTH-1:0]  a_in,
    input  logic signed [DATA_WIDTH-1:0]  b_in,
    output logic signed [2*DATA_WIDTH-1:0] result_out
);

    localparam int RW = 2 * DATA_WIDTH;

    logic signed [RW-1:0] a_x;
    logic signed [RW-1:0] b_x;

    // Sign-extend first so every operation is computed at full result width.
    assign a_x = RW'(a_in);
    assign b_x = RW'(b_in);

    // Opcode decode.
    always_comb begin
        result_out = '0;
        case (sel_in)
            ADD, ADD2: result_out = a_x + b_x;
            SUB:       result_out = a_x - b_x;
            MUL:       result_out = a_x * b_x;
            AND:       result_out = a_x & b_x;
            OR:        result_out = a_x | b_x;
            default:   result_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry tagged result buffer and valid/ready backpressure.
// Optional grant counters: define ALU_RR_ARBITER_STATS_EN.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_rr_arbiter_if.slave   arb_if
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]       grant_cnt0_out,
    output logic [15:0]       grant_cnt1_out
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]                     state_q, state_d;
    logic [REQ_ID_W-1:0]            ptr_q, ptr_d;
    logic [REQ_ID_W-1:0]            rsp_id_q, rsp_id_d;
    logic signed [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                           can_accept;
    logic                           gnt_vld;
    logic [REQ_ID_W-1:0]            gnt_id;
    alu_req_t                       req_mux;
    logic signed [2*DATA_WIDTH-1:0] alu_res;

    // Buffer may be refilled in the cycle it drains; nothing is accepted in reset.
    assign can_accept = !rst && ((state_q == ST_EMPTY) || arb_if.rsp_ready_in);

    // Grant: a lone requester wins outright, contention follows the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        if (can_accept) begin
            if (arb_if.req0_valid_in && arb_if.req1_valid_in) begin
                gnt_vld = 1'b1;
                gnt_id  = ptr_q;
            end else if (arb_if.req0_valid_in) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (arb_if.req1_valid_in) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign arb_if.req0_ready_out = gnt_vld && (gnt_id == 1'b0);
    assign arb_if.req1_ready_out = gnt_vld && (gnt_id == 1'b1);

    // Operand mux; ALU sees zeros when nobody is granted.
    always_comb begin
        req_mux = '0;
        if (gnt_vld) begin
            if (gnt_id == 1'b1) begin
                req_mux.sel = arb_if.req1_sel_in;
                req_mux.a   = arb_if.req1_a_in;
                req_mux.b   = arb_if.req1_b_in;
            end else begin
                req_mux.sel = arb_if.req0_sel_in;
                req_mux.a   = arb_if.req0_a_in;
                req_mux.b   = arb_if.req0_b_in;
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) alu_inst (
        .sel_in     (req_mux.sel),
        .a_in       (req_mux.a),
        .b_in       (req_mux.b),
        .result_out (alu_res)
    );

    // Next state: load on accept, empty on drain-only, hold when stalled.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (gnt_vld) begin
            state_d    = ST_FULL;
            ptr_d      = ~gnt_id;
            rsp_id_d   = gnt_id;
            rsp_data_d = alu_res;
        end else if (arb_if.rsp_ready_in) begin
            state_d    = ST_EMPTY;
        end
    end

    // Result buffer, FSM and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign arb_if.rsp_valid_out = (state_q == ST_FULL);
    assign arb_if.rsp_id_out    = rsp_id_q;
    assign arb_if.rsp_data_out  = rsp_data_q;

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (arb_if.req0_ready_out && arb_if.req0_valid_in && cnt0_q != 16'hFFFF)
                cnt0_q <= cnt0_q + 16'd1;
            if (arb_if.req1_ready_out && arb_if.req1_valid_in && cnt1_q != 16'hFFFF)
                cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0_out = cnt0_q;
    assign grant_cnt1_out = cnt1_q;
`endif

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU instance between two requesters (REQ0, REQ1) using round-robin arbitration.
- Registers the ALU result into a single-entry output buffer with valid/ready backpressure.
- Tags each result with the ID of the requester that issued it.
- Sits between two operand-producing blocks and one result consumer; it is the only block that drives the ALU's sel_in, a_in and b_in.

Parameters:
- DATA_WIDTH, 4, operand width in bits; result width is 2*DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid_in  in  1  REQ0 has an operation pending.
- req0_ready_out  out  1  REQ0 operation is accepted this cycle.
- req0_sel_in  in  3  REQ0 opcode.
- req0_a_in  in  DATA_WIDTH  REQ0 signed operand A.
- req0_b_in  in  DATA_WIDTH  REQ0 signed operand B.
- req1_valid_in, req1_ready_out, req1_sel_in, req1_a_in, req1_b_in: same as REQ0, for REQ1.
- rsp_valid_out  out  1  result buffer holds a result.
- rsp_ready_in  in  1  consumer takes the result this cycle.
- rsp_id_out  out  1  requester that produced the result (0 or 1).
- rsp_data_out  out  2*DATA_WIDTH  signed ALU result.

Behaviour:
- Reset (asynchronous, immediate): rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, round-robin priority pointer=0 (REQ0 preferred); both ready outputs go low combinationally.
- Handshake: a transfer occurs when valid and ready are both high on a rising clk edge. Requesters must hold sel, a and b stable while valid is high.
- can_accept = !rsp_valid_out || rsp_ready_in. The output buffer can be refilled in the same cycle it drains, so a full-rate stream is sustained.
- Grant (combinational), only when can_accept:
  - Only one requester valid: grant it.
  - Both valid: grant the requester indicated by the pointer.
  - reqN_ready_out = can_accept && granted==N. At most one ready is high per cycle.
- ALU operands are muxed from the granted requester. With no grant, the ALU inputs are driven to zero.
- On a granted transfer:
  - Result buffer loads the ALU output; rsp_id_out loads the grant ID; rsp_valid_out is set.
  - Pointer moves to the other requester (granted^1).
  - Latency is 1 cycle from the accepting edge to rsp_valid_out.
- No transfer but rsp_ready_in high: rsp_valid_out is cleared. rsp_data_out and rsp_id_out hold their last values.
- Stall: rsp_valid_out high and rsp_ready_in low. Both readies are low and the buffer is held unchanged.
- Two-state FSM on rsp_valid_out:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with drain.
  - FULL -> EMPTY on drain without accept.
  - FULL holds FULL when stalled.
- Opcodes (shared ALU definition):
  - 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 add, 110/111 produce 0.
  - Add/sub/mul are signed and sign-extended to 2*DATA_WIDTH; and/or are sign-extended bitwise.
- Pointer is unchanged when only one requester is valid and not granted, or when nothing is granted.
- Reset mid-operation: a pending result is discarded; no transfer counts as accepted.

Optional Feature:
- Macro ALU_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0_out and grant_cnt1_out, 16 bits each.
  - Each counter increments on its requester's accepted transfer and saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (ADD=3'b000, SUB, MUL, AND, OR, ADD2=3'b101).
  - localparam REQ_ID_W=1.
  - Typedef alu_req_t {sel, a, b}, used by the arbiter mux.
- Sub-module: the existing ALU, instantiated once as alu_inst.
- Arbitration logic stays inline; no separate arbiter module.

Test Plan:
- Single requester, no backpressure: REQ0 sel=000, a=3, b=2, rsp_ready_in=1 -> next cycle rsp_valid_out=1, rsp_id_out=0, rsp_data_out=5.
- Contention and alternation: both valid every cycle (REQ0 sel=010 a=-3 b=4; REQ1 sel=001 a=2 b=7) -> grants alternate 0,1,0,1, with results -12 and -5, one result per cycle.
- Backpressure: rsp_ready_in=0 after first result -> both readies low, rsp_data_out held for 5 cycles; on rsp_ready_in=1 the buffer drains and refills in the same cycle.
- Opcode edges: sel=011 a=-1 b=5 -> 5; sel=100 a=4 b=1 -> 5; sel=110 -> 0; sel=010 a=-8 b=-8 -> 64.
- Asynchronous reset mid-stall: assert rst while rsp_valid_out=1 -> rsp_valid_out=0 with no clock edge; after release, REQ0 wins the first contention.
- With ALU_RR_ARBITER_STATS_EN: 10 REQ0 and 7 REQ1 transfers -> grant_cnt0_out=10, grant_cnt1_out=7.
